inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DEPTH, default 64: instruction store depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 6: pc and load address width, equal to log2(DEPTH).
REQ-003 clk  input  1: single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1: asynchronous, active-high reset.
REQ-005 load_en  input  1: writes load_data into the store at load_addr; honoured only in IDLE.
REQ-006 load_addr  input  ADDR_W: store write address.
REQ-007 load_data  input  32: instruction word to store.
REQ-008 start  input  1: begins issue at pc 0; honoured only in IDLE.
REQ-009 prog_len  input  ADDR_W+1: number of words to issue, sampled with start; range 0..DEPTH.
REQ-010 stall  input  1: holds pc and the issued word for the cycle.
REQ-011 redirect_en  input  1: branch/jump request from the CPU.
REQ-012 redirect_pc  input  ADDR_W: target word address for redirect_en.
REQ-013 Inst  output  32: registered instruction word driven to the CPU.
REQ-014 inst_valid  output  1: Inst holds a newly issued word this cycle.
REQ-015 pc  output  ADDR_W: address of the next word to issue.
REQ-016 busy  output  1: high in RUN and DONE.
REQ-017 done  output  1: one-cycle pulse at end of program.

Function
REQ-018 FSM states SHALL be IDLE, RUN and DONE.
REQ-019 IDLE: start=1 -> RUN, pc<=0, len register<=prog_len; if prog_len=0 -> DONE directly, with no word issued.
REQ-020 RUN, stall=0, redirect_en=0: Inst<=store[pc], inst_valid<=1, pc<=pc+1.
REQ-021 RUN, redirect_en=1: pc<=redirect_pc, inst_valid<=0, Inst<=0 (bubble); redirect SHALL win over a simultaneous stall.
REQ-022 RUN, stall=1 and redirect_en=0: pc and Inst held, inst_valid<=0.
REQ-023 RUN -> DONE on the edge that issues the word at pc=len-1, or when redirect_pc>=len.
REQ-024 DONE: Inst<=0, inst_valid<=0, done<=1 for exactly one cycle, then IDLE.
REQ-025 Latency: start sampled at edge N -> Inst=store[0] with inst_valid=1 after edge N+1.
REQ-026 Outside RUN, Inst SHALL be 32'h0 (NOP) and inst_valid SHALL be 0.
REQ-027 load_en and start SHALL be ignored in RUN and DONE.
REQ-028 In IDLE, load_en and start in the same cycle: the write completes; start launches; a store[0] write in that cycle is visible to the first issue.
REQ-029 pc arithmetic SHALL be ADDR_W wide; when prog_len=DEPTH the final increment wraps to 0 while entering DONE.

Reset
REQ-030 reset=1 SHALL force IDLE, pc=0, Inst=0, inst_valid=0, done=0, busy=0 and len=0 immediately, including mid-RUN.
REQ-031 Store contents SHALL NOT be reset; a program loaded before reset SHALL remain runnable afterwards.

Structure
REQ-032 A shared package SHALL hold the FSM state encodings, the NOP word (32'h0) and default DEPTH/ADDR_W.
REQ-033 The store SHALL be one sub-module, inst_store: a single write port and a combinational read port.

Verification
REQ-034 Load 0x20010001, 0x20020001, 0x00220820, 0x00221020; start with prog_len=4 -> those four words on Inst in consecutive cycles with inst_valid=1, then done pulses once and busy falls.
REQ-035 Same program; stall=1 during the 2nd issue cycle -> 0x20020001 held one extra cycle with inst_valid=0; total of 5 cycles from first issue to DONE.
REQ-036 prog_len=4; redirect_en=1 with redirect_pc=0 after word 2 -> one bubble (Inst=0), then 0x20010001 issued again.
REQ-037 prog_len=0 -> no inst_valid, done pulses on the second edge after start.
REQ-038 reset asserted mid-RUN at pc=2 -> all outputs 0 asynchronously; a restart with prog_len=4 reissues the original words.
REQ-039 load_en with load_addr=0 and load_data=0xFFFFFFFF during RUN -> store unchanged, confirmed on the next run.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch block: FSM encoding, NOP word
// and default store geometry.
package inst_fetch_pkg;
  localparam int          DEF_DEPTH  = 64;
  localparam int          DEF_ADDR_W = 6;
  localparam logic [31:0] NOP        = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/inst_store.sv
// Instruction store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset so a loaded program survives reset.
module inst_store #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues a loaded program word-by-word to the CPU with
// stall and redirect support, then pulses done.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       Inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [31:0]       inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic [31:0]       rd_data;

  // Writes share the IDLE gate with start, so a same-cycle store[0] write
  // lands before the first read in RUN.
  inst_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_store (
    .clk     (clk),
    .we_i    (load_en && (state_q == S_IDLE)),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (pc_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    inst_d  = NOP;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = '0;
          len_d   = prog_len;
          state_d = (prog_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (redirect_en) begin
          pc_d = redirect_pc;
          if ({1'b0, redirect_pc} >= len_q) state_d = S_DONE;
        end else if (stall) begin
          inst_d = inst_q;
        end else begin
          inst_d  = rd_data;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_ONE;  // wraps to 0 when the full store is issued
          if ({1'b0, pc_q} == len_q - LEN_ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign Inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
endmodule
